uart_apb_bridge: RTL
====================

UART_APB_BRIDGE -- requirements
Module: uart_apb_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, giving the APB address width (4KB slave window).
REQ-002 SHALL have parameter RESP_TIMEOUT, default 255, giving the maximum ACCESS wait cycles when timeout is compiled in.
REQ-003 SHALL have ports (name, direction, width, meaning):
- CLK in 1: single clock, rising edge.
- RSTN in 1: reset, synchronous, active-low.
- rx_data_i in 8: received byte from UART receiver.
- rx_valid_i in 1: rx byte valid.
- rx_ready_o out 1: bridge accepts rx byte.
- tx_data_o out 8: response byte to UART transmitter.
- tx_valid_o out 1: tx byte valid.
- tx_ready_i in 1: transmitter accepts byte.
- PADDR out APB_ADDR_WIDTH: APB address.
- PWDATA out 32: APB write data.
- PWRITE out 1: APB direction.
- PSEL out 1: APB select.
- PENABLE out 1: APB enable.
- PRDATA in 32: APB read data.
- PREADY in 1: APB ready.
- PSLVERR in 1: APB error.
- busy_o out 1: high in every state except IDLE.

Function
REQ-004 SHALL act as APB initiator driven by byte frames received on the rx stream; byte transfer occurs on a cycle with valid and ready both high.
REQ-005 SHALL use the states IDLE, ADDR, WDATA, SETUP, ACCESS and RESP.
REQ-006 SHALL treat the IDLE command byte 0x57 as write (to ADDR), 0x52 as read (to ADDR), and any other value as bad command (to RESP, status 0xFF, one byte).
REQ-007 SHALL in ADDR accept 4 address bytes little-endian, keep bits [APB_ADDR_WIDTH-1:0], and discard the upper bits.
REQ-008 SHALL go to WDATA after the 4th address byte for a write, or to SETUP for a read.
REQ-009 SHALL in WDATA accept 4 data bytes little-endian into PWDATA, then go to SETUP.
REQ-010 SHALL drive rx_ready_o high only in IDLE, ADDR and WDATA, and never accept a byte in any other state.
REQ-011 SHALL hold SETUP for exactly one cycle with PSEL=1, PENABLE=0, and PADDR, PWRITE and PWDATA valid.
REQ-012 SHALL in ACCESS drive PSEL=1 and PENABLE=1 until PREADY=1 (zero or more wait cycles).
REQ-013 SHALL, on the PREADY cycle, capture PRDATA and PSLVERR, drop PSEL and PENABLE on the next edge, and go to RESP.
REQ-014 SHALL keep PADDR, PWRITE and PWDATA stable from SETUP through the final ACCESS cycle.
REQ-015 SHALL in RESP send the status byte first (0x00 OK, 0x01 PSLVERR, 0x02 timeout, 0xFF bad command).
REQ-016 SHALL, for a read with status 0x00 or 0x01, follow the status byte with 4 bytes of captured PRDATA, little-endian.
REQ-017 SHALL hold tx_data_o stable while tx_valid_o=1 and tx_ready_i=0, and keep tx_valid_o high until the byte is accepted.
REQ-018 SHALL return to IDLE on the cycle after the last response byte is accepted.
REQ-019 SHALL count frame bytes with a 2-bit counter that wraps 3->0 on each ADDR or WDATA exit; the counter SHALL be cleared in IDLE.
REQ-020 SHALL give back-to-back frames no dead cycle beyond the IDLE cycle, where rx_ready_o=1.
REQ-021 SHALL have minimum APB latency from last frame byte to PSEL=1 of 1 cycle.

Reset
REQ-022 SHALL, while RSTN=0 at a rising CLK edge, enter IDLE and clear the byte counter, PADDR, PWDATA and the captured data to 0.
REQ-023 SHALL drive outputs after reset as: PSEL=0, PENABLE=0, PWRITE=0, tx_valid_o=0, rx_ready_o=1, busy_o=0.
REQ-024 SHALL abort any frame or APB transfer in progress on reset with no response sent; PSEL SHALL drop on that edge.

Configuration
REQ-025 SHALL, with UART_APB_BRIDGE_TIMEOUT_EN defined, count ACCESS cycles with PREADY=0.
REQ-026 SHALL, with UART_APB_BRIDGE_TIMEOUT_EN defined and RESP_TIMEOUT such cycles counted, drop PSEL and PENABLE, go to RESP with status 0x02 and no data bytes, and discard PRDATA.
REQ-027 SHALL, with UART_APB_BRIDGE_TIMEOUT_EN undefined, omit the counter and wait in ACCESS indefinitely.

Verification
REQ-028 SHALL cover: rx 57 10 00 00 00 EF BE AD DE, PREADY=1 -> one SETUP cycle with PADDR=0x010, PWDATA=0xDEADBEEF, PWRITE=1, then ACCESS, then tx 00.
REQ-029 SHALL cover: rx 52 14 00 00 00, PRDATA=0x12345678, PREADY after 3 waits -> PENABLE high 4 cycles, then tx 00 78 56 34 12.
REQ-030 SHALL cover: read with PSLVERR=1, PRDATA=0xCAFEF00D -> tx 01 0D F0 FE CA.
REQ-031 SHALL cover: rx 41 -> tx FF, then IDLE with no APB activity.
REQ-032 SHALL cover: tx_ready_i=0 for 10 cycles during a read response -> tx_data_o and tx_valid_o stable, rx_ready_o=0, and no bytes lost.
REQ-033 SHALL cover: with UART_APB_BRIDGE_TIMEOUT_EN, PREADY stuck at 0 -> PSEL drops after 255 ACCESS cycles and tx 02; without the macro, PSEL stays high; RSTN=0 mid-ACCESS -> PSEL=0 next edge and busy_o=0.

Source files
------------

// File: rtl/uart_apb_bridge.sv
// uart_apb_bridge: byte-stream command frames in, one APB transfer out, status/read data back.
//   Frame (rx): 0x57 A0 A1 A2 A3 D0 D1 D2 D3 = write, 0x52 A0 A1 A2 A3 = read (little-endian).
//   Response (tx): status (00 ok, 01 slave error, 02 timeout, FF bad command), then 4 read-data bytes
//   for a read that completed with status 00/01.
// Ports:
//   CLK, RSTN             clock, synchronous active-low reset
//   rx_data_i/valid/ready byte stream from UART receiver
//   tx_data_o/valid/ready byte stream to UART transmitter
//   PADDR..PSLVERR        APB initiator
//   busy_o                high whenever the bridge is not idle
// Optional: `define UART_APB_BRIDGE_TIMEOUT_EN to abort an ACCESS phase after RESP_TIMEOUT wait cycles.
module uart_apb_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned RESP_TIMEOUT   = 255
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      rx_ready_o,
  output logic [7:0]                tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy_o
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, SETUP, ACCESS, RESP} state_e;

  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] CMD_READ   = 8'h52;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_SLVERR  = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BADCMD  = 8'hFF;

  // Elaboration-time parameter range guards
  if (APB_ADDR_WIDTH < 1 || APB_ADDR_WIDTH > 32) begin : g_bad_addr_width
    $error("uart_apb_bridge: APB_ADDR_WIDTH must be 1..32");
  end
  if (RESP_TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_apb_bridge: RESP_TIMEOUT must be at least 1");
  end

  state_e                      state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;        // frame byte index, wraps 3->0
  logic [2:0]                  tx_idx_q, tx_idx_d;  // index of response byte on tx_data_o
  logic [2:0]                  tx_last_q, tx_last_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_d;
  logic [31:0]                 pwdata_d;
  logic                        pwrite_d;
  logic [7:0]                  tx_data_d;
  logic                        tx_valid_d;
  logic [31:0]                 addr_word;
  logic                        rx_fire;
  logic                        tx_fire;

`ifdef UART_APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(RESP_TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  assign rx_fire = rx_valid_i & rx_ready_o;
  assign tx_fire = tx_valid_o & tx_ready_i;

  // Next-state and next-register-value logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_last_d  = tx_last_q;
    rdata_d    = rdata_q;
    paddr_d    = PADDR;
    pwdata_d   = PWDATA;
    pwrite_d   = PWRITE;
    tx_data_d  = tx_data_o;
    tx_valid_d = 1'b0;
    addr_word  = 32'(PADDR);
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
    tmr_d      = tmr_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (rx_fire) begin
          if (rx_data_i == CMD_WRITE) begin
            pwrite_d = 1'b1;
            state_d  = ADDR;
          end else if (rx_data_i == CMD_READ) begin
            pwrite_d = 1'b0;
            state_d  = ADDR;
          end else begin
            state_d    = RESP;
            tx_data_d  = ST_BADCMD;
            tx_valid_d = 1'b1;
            tx_idx_d   = 3'd0;
            tx_last_d  = 3'd0;
          end
        end
      end
      ADDR: begin
        if (rx_fire) begin
          // Bytes beyond the address width land in discarded upper bits
          addr_word[{cnt_q, 3'b000} +: 8] = rx_data_i;
          paddr_d = APB_ADDR_WIDTH'(addr_word);
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = PWRITE ? WDATA : SETUP;
        end
      end
      WDATA: begin
        if (rx_fire) begin
          pwdata_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
        tmr_d   = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          rdata_d    = PRDATA;
          state_d    = RESP;
          tx_data_d  = PSLVERR ? ST_SLVERR : ST_OK;
          tx_valid_d = 1'b1;
          tx_idx_d   = 3'd0;
          tx_last_d  = PWRITE ? 3'd0 : 3'd4;
        end
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
        else if (tmr_q == TMR_W'(RESP_TIMEOUT - 1)) begin
          // This is the last allowed wait cycle: give up, PRDATA not captured
          state_d    = RESP;
          tx_data_d  = ST_TIMEOUT;
          tx_valid_d = 1'b1;
          tx_idx_d   = 3'd0;
          tx_last_d  = 3'd0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
`endif
      end
      RESP: begin
        tx_valid_d = 1'b1;
        if (tx_fire) begin
          if (tx_idx_q == tx_last_q) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
          end else begin
            // Response byte k+1 is read-data byte k
            tx_idx_d  = tx_idx_q + 3'd1;
            tx_data_d = rdata_q[{tx_idx_q[1:0], 3'b000} +: 8];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; strobes are decoded from the next state
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      tx_idx_q   <= 3'd0;
      tx_last_q  <= 3'd0;
      rdata_q    <= 32'd0;
      PADDR      <= '0;
      PWDATA     <= 32'd0;
      PWRITE     <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      tx_data_o  <= 8'd0;
      tx_valid_o <= 1'b0;
      rx_ready_o <= 1'b1;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_last_q  <= tx_last_d;
      rdata_q    <= rdata_d;
      PADDR      <= paddr_d;
      PWDATA     <= pwdata_d;
      PWRITE     <= pwrite_d;
      PSEL       <= (state_d == SETUP) || (state_d == ACCESS);
      PENABLE    <= (state_d == ACCESS);
      tx_data_o  <= tx_data_d;
      tx_valid_o <= tx_valid_d;
      rx_ready_o <= (state_d == IDLE) || (state_d == ADDR) || (state_d == WDATA);
      busy_o     <= (state_d != IDLE);
    end
  end

`ifdef UART_APB_BRIDGE_TIMEOUT_EN
  // ACCESS wait-cycle counter
  always_ff @(posedge CLK) begin
    if (!RSTN) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`endif

endmodule
